// File: rtl/bus_arbiter_pkg.sv
// Shared bus constants, owner encodings and the active-low grant decode used by the arbiter.
package bus_arbiter_pkg;

  localparam int unsigned BUS_MASTER_CH = 4;
  localparam int unsigned BUS_OWNER_W   = 2;

  typedef logic [BUS_OWNER_W-1:0] bus_owner_t;

  localparam bus_owner_t BUS_OWNER_MASTER_0 = 2'd0;
  localparam bus_owner_t BUS_OWNER_MASTER_1 = 2'd1;
  localparam bus_owner_t BUS_OWNER_MASTER_2 = 2'd2;
  localparam bus_owner_t BUS_OWNER_MASTER_3 = 2'd3;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // One-hot decode of the owner, inverted so that only the owner's grant is low.
  function automatic logic [BUS_MASTER_CH-1:0] grnt_decode(bus_owner_t owner);
    logic [BUS_MASTER_CH-1:0] g;
    g        = {BUS_MASTER_CH{DISABLE_}};
    g[owner] = ENABLE_;
    return g;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the round-robin arbiter.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic       m0_req_;
  logic       m1_req_;
  logic       m2_req_;
  logic       m3_req_;
  logic       m0_grnt_;
  logic       m1_grnt_;
  logic       m2_grnt_;
  logic       m3_grnt_;
  bus_owner_t owner;

  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner
  );

  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, owner
  );

endinterface

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin search: first requester after the current owner, wrapping around.
module bus_arb_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [BUS_MASTER_CH-1:0] req,
  input  bus_owner_t               owner,
  input  logic                     exclude_owner,
  output bus_owner_t               next_owner,
  output logic                     found
);

  bus_owner_t cand;

  always_comb begin
    next_owner = owner;
    found      = 1'b0;
    cand       = owner;
    // Walk farthest-first so the nearest requester after owner wins; offset 4 is owner itself.
    for (int unsigned i = BUS_MASTER_CH; i >= 1; i--) begin
      cand = owner + BUS_OWNER_W'(i);
      if (req[cand] && !(i == BUS_MASTER_CH && exclude_owner)) begin
        next_owner = cand;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with parking on the last owner and optional forced rotation.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 0,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic          clk,
  input  logic          reset_,
  bus_arbiter_if.slave  bus
);

  localparam logic [HOLD_W-1:0] HoldLast = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  logic [BUS_MASTER_CH-1:0] req;
  logic [BUS_MASTER_CH-1:0] grnt_q;
  bus_owner_t               owner_q, owner_d, pick_owner;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic                     pick_found, owner_req, force_rot;

  // Internal request vector is active-high.
  assign req       = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};
  assign owner_req = req[owner_q];

  // While the owner requests, only other masters count as candidates.
  bus_arb_rr_pick u_pick (
    .req           (req),
    .owner         (owner_q),
    .exclude_owner (owner_req),
    .next_owner    (pick_owner),
    .found         (pick_found)
  );

  assign force_rot = (MAX_HOLD != 0) && owner_req && (hold_q == HoldLast) && pick_found;

  always_comb begin
    owner_d = owner_q;
    hold_d  = hold_q;
    if (!owner_req || force_rot) begin
      hold_d = '0;
      if (pick_found) owner_d = pick_owner;
    end else if (hold_q != '1) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      owner_q <= BUS_OWNER_MASTER_0;
      hold_q  <= '0;
      grnt_q  <= grnt_decode(BUS_OWNER_MASTER_0);
    end else begin
      owner_q <= owner_d;
      hold_q  <= hold_d;
      grnt_q  <= grnt_decode(owner_d);
    end
  end

  assign bus.m0_grnt_ = grnt_q[0];
  assign bus.m1_grnt_ = grnt_q[1];
  assign bus.m2_grnt_ = grnt_q[2];
  assign bus.m3_grnt_ = grnt_q[3];
  assign bus.owner    = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one instance without and one with forced rotation (MAX_HOLD=4).
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst0_ = 1'b0;
  logic rst4_ = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bus_arbiter_if bus0 ();
  bus_arbiter_if bus4 ();

  bus_arbiter #(.MAX_HOLD(0), .HOLD_W(5)) dut0 (.clk(clk), .reset_(rst0_), .bus(bus0));
  bus_arbiter #(.MAX_HOLD(4), .HOLD_W(5)) dut4 (.clk(clk), .reset_(rst4_), .bus(bus4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request vectors are {m3,m2,m1,m0}, active-low.
  task automatic drive0(input logic [3:0] r);
    {bus0.m3_req_, bus0.m2_req_, bus0.m1_req_, bus0.m0_req_} = r;
  endtask

  task automatic drive4(input logic [3:0] r);
    {bus4.m3_req_, bus4.m2_req_, bus4.m1_req_, bus4.m0_req_} = r;
  endtask

  function automatic logic [3:0] g0();
    return {bus0.m3_grnt_, bus0.m2_grnt_, bus0.m1_grnt_, bus0.m0_grnt_};
  endfunction

  function automatic logic [3:0] g4();
    return {bus4.m3_grnt_, bus4.m2_grnt_, bus4.m1_grnt_, bus4.m0_grnt_};
  endfunction

  task automatic test_reset();
    drive0(4'b1111);
    drive4(4'b1111);
    rst0_ = 1'b0;
    rst4_ = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (g0() !== 4'b1110 || bus0.owner !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_dut0: grnt=%b owner=%0d, required grnt=1110 owner=0", g0(), bus0.owner);
    end
    n_cmp++;
    if (g4() !== 4'b1110 || bus4.owner !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_dut4: grnt=%b owner=%0d, required grnt=1110 owner=0", g4(), bus4.owner);
    end
    rst0_ = 1'b1;
    rst4_ = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (g0() !== 4'b1110 || bus0.owner !== 2'd0) begin
        n_fail++;
        $display("FAIL park_idle c=%0d: grnt=%b owner=%0d, required grnt=1110 owner=0",
                 c, g0(), bus0.owner);
      end
    end
  endtask

  task automatic test_single_handover();
    drive0(4'b1011);
    #2;
    n_cmp++;
    if (g0() !== 4'b1110) begin
      n_fail++;
      $display("FAIL no_comb_path: grnt=%b, required 1110 before the edge", g0());
    end
    tick();
    n_cmp++;
    if (g0() !== 4'b1011 || bus0.owner !== 2'd2) begin
      n_fail++;
      $display("FAIL handover_0_to_2: grnt=%b owner=%0d, required grnt=1011 owner=2",
               g0(), bus0.owner);
    end
    drive0(4'b1111);
    tick();
    tick();
    n_cmp++;
    if (g0() !== 4'b1011 || bus0.owner !== 2'd2) begin
      n_fail++;
      $display("FAIL park_on_2: grnt=%b owner=%0d, required grnt=1011 owner=2", g0(), bus0.owner);
    end
    drive0(4'b1011);
    tick();
    n_cmp++;
    if (g0() !== 4'b1011) begin
      n_fail++;
      $display("FAIL parked_rerequest: grnt=%b, required 1011", g0());
    end
  endtask

  task automatic test_rotation();
    logic [1:0] e;
    logic [3:0] eg;
    logic [3:0] r;
    drive0(4'b1111);
    rst0_ = 1'b0;
    tick();
    rst0_ = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e  = 2'(k % 4);
      eg = ~(4'b0001 << e);
      for (int c = 0; c < 4; c++) begin
        n_cmp++;
        if (g0() !== eg || bus0.owner !== e) begin
          n_fail++;
          $display("FAIL rotation k=%0d c=%0d: grnt=%b owner=%0d, required grnt=%b owner=%0d",
                   k, c, g0(), bus0.owner, eg, e);
        end
        r = 4'b0000;
        if (c == 3) r[e] = 1'b1;
        drive0(r);
        tick();
      end
    end
    n_cmp++;
    if (bus0.owner !== 2'd0) begin
      n_fail++;
      $display("FAIL rotation_wrap_end: owner=%0d, required 0", bus0.owner);
    end
  endtask

  task automatic test_wrap_around();
    drive0(4'b1111);
    rst0_ = 1'b0;
    tick();
    rst0_ = 1'b1;
    drive0(4'b0111);
    tick();
    n_cmp++;
    if (g0() !== 4'b0111 || bus0.owner !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_to_3: grnt=%b owner=%0d, required grnt=0111 owner=3", g0(), bus0.owner);
    end
    drive0(4'b1001);
    tick();
    n_cmp++;
    if (g0() !== 4'b1101 || bus0.owner !== 2'd1) begin
      n_fail++;
      $display("FAIL wrap_3_to_1: grnt=%b owner=%0d, required grnt=1101 owner=1", g0(), bus0.owner);
    end
    drive0(4'b0111);
    tick();
    n_cmp++;
    if (g0() !== 4'b0111 || bus0.owner !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_1_to_3: grnt=%b owner=%0d, required grnt=0111 owner=3", g0(), bus0.owner);
    end
  endtask

  task automatic test_forced_rotation();
    drive4(4'b1111);
    rst4_ = 1'b0;
    tick();
    rst4_ = 1'b1;
    drive4(4'b1101);
    tick();
    // Tenure cycle 1 of master 1; master 3 joins after it.
    tick();
    drive4(4'b0101);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (bus4.owner !== 2'd1) begin
        n_fail++;
        $display("FAIL forced_hold c=%0d: owner=%0d, required 1", c, bus4.owner);
      end
    end
    tick();
    n_cmp++;
    if (g4() !== 4'b0111 || bus4.owner !== 2'd3) begin
      n_fail++;
      $display("FAIL forced_to_3: grnt=%b owner=%0d, required grnt=0111 owner=3", g4(), bus4.owner);
    end
    for (int c = 0; c < 3; c++) tick();
    n_cmp++;
    if (bus4.owner !== 2'd3) begin
      n_fail++;
      $display("FAIL forced_hold_3: owner=%0d, required 3", bus4.owner);
    end
    tick();
    n_cmp++;
    if (g4() !== 4'b1101 || bus4.owner !== 2'd1) begin
      n_fail++;
      $display("FAIL forced_back_to_1: grnt=%b owner=%0d, required grnt=1101 owner=1",
               g4(), bus4.owner);
    end
    // Without forced rotation, master 1 keeps the bus.
    drive0(4'b1111);
    rst0_ = 1'b0;
    tick();
    rst0_ = 1'b1;
    drive0(4'b1101);
    tick();
    drive0(4'b0101);
    for (int c = 0; c < 20; c++) tick();
    n_cmp++;
    if (g0() !== 4'b1101 || bus0.owner !== 2'd1) begin
      n_fail++;
      $display("FAIL no_forced_rotation: grnt=%b owner=%0d, required grnt=1101 owner=1",
               g0(), bus0.owner);
    end
  endtask

  task automatic test_reset_mid();
    drive4(4'b1011);
    tick();
    tick();
    tick();
    tick();
    n_cmp++;
    if (bus4.owner !== 2'd2) begin
      n_fail++;
      $display("FAIL mid_setup: owner=%0d, required 2", bus4.owner);
    end
    rst4_ = 1'b0;
    tick();
    n_cmp++;
    if (g4() !== 4'b1110 || bus4.owner !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset: grnt=%b owner=%0d, required grnt=1110 owner=0", g4(), bus4.owner);
    end
    rst4_ = 1'b1;
    // Masters 0 and 1 request: a fresh counter gives master 0 a full 4-cycle tenure.
    drive4(4'b1100);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (bus4.owner !== 2'd0) begin
        n_fail++;
        $display("FAIL mid_hold_restart c=%0d: owner=%0d, required 0", c, bus4.owner);
      end
    end
    tick();
    n_cmp++;
    if (g4() !== 4'b1101 || bus4.owner !== 2'd1) begin
      n_fail++;
      $display("FAIL mid_forced_after_reset: grnt=%b owner=%0d, required grnt=1101 owner=1",
               g4(), bus4.owner);
    end
  endtask

  initial begin
    drive0(4'b1111);
    drive4(4'b1111);
    test_reset();
    test_single_handover();
    test_rotation();
    test_wrap_around();
    test_forced_rotation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
